fft_butterfly: RTL

FFT_BUTTERFLY -- requirements
Module: fft_butterfly

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_cmul.sv | 54 +++++
 rtl/fft_butterfly.sv | 86 ++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared default width, complex type and rounding/saturation constants
package fft_pkg;
  localparam int FFT_DW_DEFAULT = 16;
  typedef struct packed {
    logic signed [FFT_DW_DEFAULT-1:0] re;
    logic signed [FFT_DW_DEFAULT-1:0] im;
  } cplx_t;
  function automatic longint rnd_of(input int w);
    return longint'(1) << (w - 2);
  endfunction
  function automatic longint max_of(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint min_of(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
  localparam longint RND     = rnd_of(FFT_DW_DEFAULT);
  localparam longint SAT_MAX = max_of(FFT_DW_DEFAULT);
  localparam longint SAT_MIN = min_of(FFT_DW_DEFAULT);
endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: three-stage complex multiply B*W (optionally conjugated W) with round half up
module fft_cmul
  import fft_pkg::*;
#(
  parameter int FFT_DW = FFT_DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     ifft,
  input  logic signed [FFT_DW-1:0] b_real,
  input  logic signed [FFT_DW-1:0] b_imag,
  input  logic signed [FFT_DW-1:0] tw_real,
  input  logic signed [FFT_DW-1:0] tw_imag,
  output logic                     out_valid,
  output logic signed [FFT_DW:0]   p_real,
  output logic signed [FFT_DW:0]   p_imag
);
  localparam int PW = 2 * FFT_DW + 1;
  localparam int MW = 2 * FFT_DW;
  localparam logic signed [PW-1:0] RND_W = PW'(rnd_of(FFT_DW));
  localparam logic signed [FFT_DW-1:0] TMAX = FFT_DW'(max_of(FFT_DW));
  localparam logic signed [FFT_DW-1:0] TMIN = FFT_DW'(min_of(FFT_DW));
  logic [1:0] v_q;
  logic signed [FFT_DW-1:0] br_q, bi_q, wr_q, wi_q, wi_d;
  logic signed [MW-1:0] mrr_q, mii_q, mri_q, mir_q;
  logic signed [PW-1:0] rr_d, ri_d;
  logic unused_bits;
  assign unused_bits = ^{rr_d[PW-1], rr_d[FFT_DW-2:0], ri_d[PW-1], ri_d[FFT_DW-2:0]};
  // conjugate the twiddle for the inverse transform; negating the most negative code saturates
  always_comb wi_d = !ifft ? tw_imag : tw_imag == TMIN ? TMAX : -tw_imag;
  // combine the partial products at full precision and add the half-LSB rounding constant
  always_comb begin
    rr_d = PW'(mrr_q) - PW'(mii_q) + RND_W;
    ri_d = PW'(mri_q) + PW'(mir_q) + RND_W;
  end
  // valid pipe for stages 1-3; only these bits are cleared by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) {out_valid, v_q} <= '0;
    else {out_valid, v_q} <= {v_q, in_valid};
  // datapath: operand register, four multiplies, combine and shift down to FFT_DW+1 bits
  always_ff @(posedge clk) begin
    br_q   <= b_real;
    bi_q   <= b_imag;
    wr_q   <= tw_real;
    wi_q   <= wi_d;
    mrr_q  <= MW'(br_q) * MW'(wr_q);
    mii_q  <= MW'(bi_q) * MW'(wi_q);
    mri_q  <= MW'(br_q) * MW'(wi_q);
    mir_q  <= MW'(bi_q) * MW'(wr_q);
    p_real <= rr_d[PW-2:FFT_DW-1];
    p_imag <= ri_d[PW-2:FFT_DW-1];
  end
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: pipelined radix-2 butterfly X = A + B*W, Y = A - B*W with scaling and saturation
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int FFT_N  = 10,
  parameter int FFT_DW = FFT_DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     ifft,
  input  logic                     scale,
  input  logic signed [FFT_DW-1:0] a_real,
  input  logic signed [FFT_DW-1:0] a_imag,
  input  logic signed [FFT_DW-1:0] b_real,
  input  logic signed [FFT_DW-1:0] b_imag,
  input  logic signed [FFT_DW-1:0] tw_real,
  input  logic signed [FFT_DW-1:0] tw_imag,
  output logic                     out_valid,
  output logic signed [FFT_DW-1:0] x_real,
  output logic signed [FFT_DW-1:0] x_imag,
  output logic signed [FFT_DW-1:0] y_real,
  output logic signed [FFT_DW-1:0] y_imag,
  input  logic                     ovf_clear,
  output logic                     ovf_sticky
);
  localparam int W = FFT_DW + 2;
  localparam logic signed [W-1:0] ONE  = W'(1);
  localparam logic signed [W-1:0] SMAX = W'(max_of(FFT_DW));
  localparam logic signed [W-1:0] SMIN = W'(min_of(FFT_DW));
  localparam logic signed [FFT_DW-1:0] TMAX = FFT_DW'(max_of(FFT_DW));
  localparam logic signed [FFT_DW-1:0] TMIN = FFT_DW'(min_of(FFT_DW));
  logic signed [FFT_DW-1:0] ar_q [3];
  logic signed [FFT_DW-1:0] ai_q [3];
  logic [2:0] sc_q;
  logic bw_v, ovf_d;
  logic signed [FFT_DW:0] bw_r, bw_i;
  logic signed [W-1:0] s_d [4];
  logic unused_n;
  assign unused_n = ^FFT_N;
  function automatic logic signed [W-1:0] scl(input logic sc, input logic signed [W-1:0] v);
    return sc ? (v + ONE) >>> 1 : v;
  endfunction
  function automatic logic ov(input logic signed [W-1:0] v);
    return v > SMAX || v < SMIN;
  endfunction
  function automatic logic signed [FFT_DW-1:0] sat(input logic signed [W-1:0] v);
    return v > SMAX ? TMAX : v < SMIN ? TMIN : v[FFT_DW-1:0];
  endfunction
  fft_cmul #(.FFT_DW(FFT_DW)) u_cmul (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ifft(ifft),
    .b_real(b_real), .b_imag(b_imag), .tw_real(tw_real), .tw_imag(tw_imag),
    .out_valid(bw_v), .p_real(bw_r), .p_imag(bw_i)
  );
  // carry A and the scale flag alongside the three multiplier stages
  always_ff @(posedge clk) begin
    ar_q <= '{a_real, ar_q[0], ar_q[1]};
    ai_q <= '{a_imag, ai_q[0], ai_q[1]};
    sc_q <= {sc_q[1:0], scale};
  end
  // sum/difference with optional halving; overflow only counts for a valid sample
  always_comb begin
    s_d[0] = scl(sc_q[2], W'(ar_q[2]) + W'(bw_r));
    s_d[1] = scl(sc_q[2], W'(ai_q[2]) + W'(bw_i));
    s_d[2] = scl(sc_q[2], W'(ar_q[2]) - W'(bw_r));
    s_d[3] = scl(sc_q[2], W'(ai_q[2]) - W'(bw_i));
    ovf_d  = bw_v & (ov(s_d[0]) | ov(s_d[1]) | ov(s_d[2]) | ov(s_d[3]));
  end
  // output stage: load saturated results on valid, hold otherwise; a new overflow beats clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      x_real     <= '0;
      x_imag     <= '0;
      y_real     <= '0;
      y_imag     <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid  <= bw_v;
      x_real     <= bw_v ? sat(s_d[0]) : x_real;
      x_imag     <= bw_v ? sat(s_d[1]) : x_imag;
      y_real     <= bw_v ? sat(s_d[2]) : y_real;
      y_imag     <= bw_v ? sat(s_d[3]) : y_imag;
      ovf_sticky <= ovf_d | (ovf_sticky & ~ovf_clear);
    end
endmodule
